serial_adder: RTL and testbench

Bit-serial ripple adder that takes two WIDTH-bit operands plus carry-in through a valid/ready handshake. It instantiates one `full_adder` cell and drives it one bit per clock, LSB first, with the carry held in a flip-flop between bits. The registered sum and carry-out are presented on a valid/ready output port. It is the sequential consumer of the `full_adder` cell: the cell's `sum`/`carry` outputs feed this block's result shift register and carry register.

---
 rtl/serial_adder.sv | 178 +++++++++++++++++
 tb/tb_serial_adder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built around a single full_adder cell.
// Operands are accepted on a valid/ready handshake, added one bit per clock
// (LSB first) with the carry held in a flip-flop between bits, and the
// registered sum/carry-out is offered on a valid/ready result port.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   a/b/cin carry a valid operand set
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       WIDTH-bit operands, sampled on the input handshake
//   cin        carry-in, sampled on the input handshake
//   out_valid  sum/cout hold a completed result
//   out_ready  downstream accepts the result
//   sum        registered (a + b + cin) mod 2^WIDTH
//   cout       registered carry out of the MSB
//   busy       high while a result is being computed or waiting to be taken

// One-bit full adder cell driven by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic              carry_r;
  logic [WIDTH-1:0]  a_sr_r;
  logic [WIDTH-1:0]  b_sr_r;
  logic [WIDTH-1:0]  res_sr_r;
  logic [WIDTH-1:0]  res_nxt_s;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              fa_sum_s;
  logic              fa_carry_s;
  logic              accept_s;
  logic              last_s;

  // in_ready is forced low while reset is asserted so nothing is taken then.
  assign in_ready  = (state_r == IDLE) & ~rst;
  assign accept_s  = in_valid & in_ready;
  assign last_s    = (cnt_r == CNT_LAST);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign busy      = busy_r;

  full_adder u_fa (
    .a     (a_sr_r[0]),
    .b     (b_sr_r[0]),
    .cin   (carry_r),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  // Result register shifts right; the new sum bit enters at the MSB so that
  // after WIDTH shifts the first (LSB) sum bit has reached bit 0.
  always_comb begin
    res_nxt_s            = res_sr_r >> 1'b1;
    res_nxt_s[WIDTH-1]   = fa_sum_s;
  end

  // Next-state decode for the IDLE/RUN/DONE control FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        // No bypass: returning to IDLE here means a new operand set can only
        // be accepted on the edge after the output handshake.
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus a registered busy flag derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Serial datapath: operand shift registers, carry flop, counter, result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= CNT_ZERO;
      carry_r     <= 1'b0;
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      res_sr_r    <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            carry_r  <= cin;
            cnt_r    <= CNT_ZERO;
            res_sr_r <= '0;
          end
        end
        RUN: begin
          res_sr_r <= res_nxt_s;
          carry_r  <= fa_carry_s;
          a_sr_r   <= a_sr_r >> 1'b1;
          b_sr_r   <= b_sr_r >> 1'b1;
          cnt_r    <= cnt_r + CNT_ONE;
          if (last_s) begin
            sum_r       <= res_nxt_s;
            cout_r      <= fa_carry_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          // sum/cout keep their value after the handshake until the next result.
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: one WIDTH=8 and one WIDTH=1 instance,
// directed and random operands checked against plain-arithmetic expectations.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0] a8, b8, sum8;

  logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
  logic [0:0] a1, b1, sum1;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8),
    .busy(busy8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1),
    .busy(busy1)
  );

  // Reference: full-precision integer sum; low 8 bits = sum, bit 8 = carry.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[8:0];
  endfunction

  // Drive one operand set into the 8-bit instance, scramble inputs while it
  // works, and return the result plus the number of edges after the accept
  // edge until out_valid was seen (40 means it never came).
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      output logic [7:0] s, output logic co, output int lat);
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ov8 === 1'b1) break;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'($urandom);
    end
    iv8 = 1'b0;
    s = sum8; co = cout8;
    if (or8 === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv8 = 1'b0; iv1 = 1'b0; or8 = 1'b1; or1 = 1'b1;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #12;
    total++;
    if ({sum8, cout8, ov8, busy8, ir8} !== 12'h000) begin
      bad++; $display("FAIL reset_hold: got sum=%h cout=%b ov=%b busy=%b ir=%b want all 0", sum8, cout8, ov8, busy8, ir8);
    end
    total++;
    if (ir1 !== 1'b0) begin bad++; $display("FAIL reset_hold_w1: in_ready=%b want 0", ir1); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ir8 !== 1'b1 || ir1 !== 1'b1) begin
      bad++; $display("FAIL reset_release: in_ready w8=%b w1=%b want 1", ir8, ir1);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta[4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    logic [7:0] tb[4] = '{8'h00, 8'h01, 8'h5A, 8'h42};
    logic       tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] s; logic co; int lat; logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      e = ref8(ta[i], tb[i], tc[i]);
      run8(ta[i], tb[i], tc[i], s, co, lat);
      total++;
      if (lat !== 8) begin bad++; $display("FAIL dir_latency[%0d]: got %0d edges want 8", i, lat); end
      total++;
      if ({co, s} !== e) begin bad++; $display("FAIL dir_result[%0d]: got cout=%b sum=%h want cout=%b sum=%h", i, co, s, e[8], e[7:0]); end
      total++;
      if (ov8 !== 1'b0 || sum8 !== e[7:0] || cout8 !== e[8]) begin
        bad++; $display("FAIL dir_hold[%0d]: ov=%b sum=%h cout=%b want ov=0 sum=%h cout=%b", i, ov8, sum8, cout8, e[7:0], e[8]);
      end
    end
  endtask

  task automatic test_width1();
    int lat; logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); iv1 = 1'b1;
      e = 2'(int'(a1) + int'(b1) + int'(cin1));
      @(posedge clk); #1;
      iv1 = 1'b0;
      lat = 0;
      while (lat < 20) begin
        @(posedge clk); #1;
        lat++;
        if (ov1 === 1'b1) break;
      end
      total++;
      if (lat !== 1) begin bad++; $display("FAIL w1_latency[%0d]: got %0d edges want 1", i, lat); end
      total++;
      if ({cout1, sum1} !== e) begin bad++; $display("FAIL w1_result[%0d]: got cout=%b sum=%b want cout=%b sum=%b", i, cout1, sum1, e[1], e[0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] s; logic co; int lat;
    or8 = 1'b0;
    run8(8'h80, 8'h80, 1'b0, s, co, lat);
    total++;
    if ({co, s} !== 9'h100 || lat !== 8) begin
      bad++; $display("FAIL bp_result: got cout=%b sum=%h lat=%0d want cout=1 sum=00 lat=8", co, s, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (ov8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b1 || ir8 !== 1'b0) begin
        bad++; $display("FAIL bp_stall[%0d]: ov=%b sum=%h cout=%b ir=%b want 1 00 1 0", i, ov8, sum8, cout8, ir8);
      end
    end
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      bad++; $display("FAIL bp_release: ov=%b ir=%b want ov=0 ir=1", ov8, ir8);
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] s; logic co; int lat; int seen;
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    total++;
    if (busy8 !== 1'b1 || ir8 !== 1'b0) begin bad++; $display("FAIL midop_busy: busy=%b ir=%b want 1 0", busy8, ir8); end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({sum8, cout8, ov8, busy8, ir8} !== 12'h000) begin
      bad++; $display("FAIL midop_reset: sum=%h cout=%b ov=%b busy=%b ir=%b want all 0", sum8, cout8, ov8, busy8, ir8);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ov8 === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midop_no_valid: out_valid seen %0d times want 0", seen); end
    run8(8'h12, 8'h34, 1'b0, s, co, lat);
    total++;
    if ({co, s} !== 9'h046 || lat !== 8) begin
      bad++; $display("FAIL midop_fresh: got cout=%b sum=%h lat=%0d want cout=0 sum=46 lat=8", co, s, lat);
    end
  endtask

  task automatic test_no_bypass();
    logic [7:0] s; logic co; int lat; logic [7:0] x, y; logic [8:0] e;
    or8 = 1'b0;
    run8(8'h0F, 8'h01, 1'b0, s, co, lat);
    total++;
    if ({co, s} !== 9'h010) begin bad++; $display("FAIL nb_first: got cout=%b sum=%h want cout=0 sum=10", co, s); end
    x = 8'($urandom); y = 8'($urandom); e = ref8(x, y, 1'b1);
    @(negedge clk);
    or8 = 1'b1; a8 = x; b8 = y; cin8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b1) begin
      bad++; $display("FAIL nb_handshake_edge: ov=%b busy=%b ir=%b want 0 0 1", ov8, busy8, ir8);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    total++;
    if (busy8 !== 1'b1) begin bad++; $display("FAIL nb_next_accept: busy=%b want 1", busy8); end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ov8 === 1'b1) break;
    end
    total++;
    if ({cout8, sum8} !== e || lat !== 8) begin
      bad++; $display("FAIL nb_second: got cout=%b sum=%h lat=%0d want cout=%b sum=%h lat=8", cout8, sum8, lat, e[8], e[7:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] s; logic co; int lat; logic [7:0] x, y; logic c; logic [8:0] e;
    or8 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      e = ref8(x, y, c);
      run8(x, y, c, s, co, lat);
      total++;
      if ({co, s} !== e || lat !== 8) begin
        bad++; $display("FAIL rand[%0d] %h+%h+%b: got cout=%b sum=%h lat=%0d want cout=%b sum=%h lat=8", i, x, y, c, co, s, lat, e[8], e[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_width1();
    test_backpressure();
    test_reset_midop();
    test_no_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
